// File: rtl/sh7604_mac_seq.sv
// SH7604 MAC instruction sequencer: drives the multiplier port and fetches MAC.L/MAC.W operands.
// Optional MACSEQ_ADDR_CHECK_EN adds ADDR_ERR and aborts on misaligned pointers.
module sh7604_mac_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        EN,
    input  logic        START,
    input  logic [3:0]  OP,
    input  logic        S_FLAG,
    input  logic [31:0] RN_VAL,
    input  logic [31:0] RM_VAL,
    input  logic        SAME,
    output logic [31:0] MEM_A,
    output logic        MEM_REQ,
    output logic        MEM_WORD,
    input  logic [31:0] MEM_DI,
    input  logic        MEM_BUSY,
    output logic [1:0]  MAC_SEL,
    output logic [3:0]  MAC_OP,
    output logic        MAC_S,
    output logic        MAC_WE,
    output logic [31:0] MAC_D,
    output logic [31:0] MAC_A,
    output logic [31:0] RN_NEW,
    output logic [31:0] RM_NEW,
    output logic        PTR_WE,
    output logic        BUSY,
    output logic        DONE
`ifdef MACSEQ_ADDR_CHECK_EN
   ,output logic        ADDR_ERR
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEC, S_MUL1, S_MUL2, S_MULW, S_CLR,
        S_RD_N, S_WR_A, S_RD_M, S_WR_B, S_FIN, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [31:0] mem_a;
        logic        mem_req;
        logic        mem_word;
        logic [1:0]  mac_sel;
        logic        mac_s;
        logic        mac_we;
        logic [31:0] mac_d;
        logic [31:0] mac_a;
        logic [31:0] rn_new;
        logic [31:0] rm_new;
        logic        ptr_we;
        logic        busy;
        logic        done;
    } out_t;

    state_t      state_q, state_d;
    out_t        out_q, out_d;
    logic [3:0]  op_q;
    logic        s_q, same_q;
    logic [31:0] rn_q, rm_q;
    logic        step;

    logic [31:0] size, lowmask, addr_n, addr_m;

    assign step    = CE_R && EN;
    assign size    = op_q[1] ? 32'd2 : 32'd4;
    assign lowmask = op_q[1] ? 32'd1 : 32'd3;

`ifdef MACSEQ_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;
    logic misal;
    // With SAME the second address is Rn+size, which shares Rn's alignment.
    assign misal  = (|(rn_q & lowmask)) || (!same_q && (|(rm_q & lowmask)));
    assign addr_n = rn_q;
    assign addr_m = same_q ? rn_q + size : rm_q;
`else
    assign addr_n = rn_q & ~lowmask;
    assign addr_m = (same_q ? rn_q + size : rm_q) & ~lowmask;
`endif

    // Bus handshake: MEM_REQ with MEM_A is held until a step samples MEM_BUSY=0;
    // MEM_DI is taken on that same step.
    always_comb begin
        state_d = state_q;
        out_d   = '0;
`ifdef MACSEQ_ADDR_CHECK_EN
        addr_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (START) state_d = S_DEC;
            S_DEC: begin
                case (op_q)
                    4'b0001, 4'b0010, 4'b0011: state_d = S_MUL1;
                    4'b0110, 4'b0111:          state_d = S_MULW;
                    4'b1111:                   state_d = S_CLR;
`ifdef MACSEQ_ADDR_CHECK_EN
                    4'b1001, 4'b1011:          state_d = misal ? S_ERR : S_RD_N;
`else
                    4'b1001, 4'b1011:          state_d = S_RD_N;
`endif
                    default:                   state_d = S_DONE;
                endcase
            end
            S_MUL1:                 state_d = S_MUL2;
            S_MUL2, S_MULW, S_CLR:  state_d = S_DONE;
            S_RD_N: if (!MEM_BUSY)  state_d = S_WR_A;
            S_WR_A:                 state_d = S_RD_M;
            S_RD_M: if (!MEM_BUSY)  state_d = S_WR_B;
            S_WR_B:                 state_d = S_FIN;
            default:                state_d = S_IDLE;
        endcase

        // Outputs are a registered function of the state being entered.
        out_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_MUL1: begin out_d.mac_sel = 2'b01; out_d.mac_d = rn_q; out_d.mac_we = 1'b1; end
            S_MUL2: begin out_d.mac_sel = 2'b10; out_d.mac_d = rm_q; out_d.mac_we = 1'b1; end
            S_MULW: begin
                out_d.mac_sel = 2'b10;
                out_d.mac_d   = {rm_q[15:0], rn_q[15:0]};
                out_d.mac_we  = 1'b1;
            end
            S_CLR:  begin out_d.mac_sel = 2'b11; out_d.mac_we = 1'b1; end
            S_RD_N: begin out_d.mem_a = addr_n; out_d.mem_req = 1'b1; out_d.mem_word = op_q[1]; end
            S_WR_A: begin
                out_d.mac_sel = 2'b01;
                out_d.mac_d   = MEM_DI;
                out_d.mac_a   = addr_n;
                out_d.mac_we  = 1'b1;
            end
            S_RD_M: begin out_d.mem_a = addr_m; out_d.mem_req = 1'b1; out_d.mem_word = op_q[1]; end
            S_WR_B: begin
                out_d.mac_sel = 2'b10;
                out_d.mac_d   = MEM_DI;
                out_d.mac_a   = addr_m;
                out_d.mac_we  = 1'b1;
                out_d.mac_s   = s_q;
            end
            S_FIN: begin
                out_d.rn_new = same_q ? rn_q + (size << 1) : rn_q + size;
                out_d.rm_new = same_q ? rn_q + (size << 1) : rm_q + size;
                out_d.ptr_we = 1'b1;
                out_d.done   = 1'b1;
            end
            S_DONE: out_d.done = 1'b1;
            S_ERR: begin
                out_d.done = 1'b1;
`ifdef MACSEQ_ADDR_CHECK_EN
                addr_err_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            op_q    <= '0;
            s_q     <= 1'b0;
            same_q  <= 1'b0;
            rn_q    <= '0;
            rm_q    <= '0;
        end else if (step) begin
            state_q <= state_d;
            out_q   <= out_d;
            if (state_q == S_IDLE && START) begin
                op_q   <= OP;
                s_q    <= S_FLAG;
                same_q <= SAME;
                rn_q   <= RN_VAL;
                rm_q   <= RM_VAL;
            end
        end
    end

`ifdef MACSEQ_ADDR_CHECK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)    addr_err_q <= 1'b0;
        else if (step) addr_err_q <= addr_err_d;
    end
    assign ADDR_ERR = addr_err_q;
`endif

    assign MEM_A    = out_q.mem_a;
    assign MEM_REQ  = out_q.mem_req;
    assign MEM_WORD = out_q.mem_word;
    assign MAC_SEL  = out_q.mac_sel;
    assign MAC_OP   = op_q;
    assign MAC_S    = out_q.mac_s;
    assign MAC_WE   = out_q.mac_we;
    assign MAC_D    = out_q.mac_d;
    assign MAC_A    = out_q.mac_a;
    assign RN_NEW   = out_q.rn_new;
    assign RM_NEW   = out_q.rm_new;
    assign PTR_WE   = out_q.ptr_we;
    assign BUSY     = out_q.busy;
    assign DONE     = out_q.done;

endmodule
